// File: rtl/fp_normalize_pack_pkg.sv
// Shared FPA definitions: field widths, exponent limits, packed-float layout
// and the result classification used between the normalize stages.
package fp_normalize_pack_pkg;

    localparam int unsigned MANT_W = 24;
    localparam int unsigned SUM_W  = 25;
    localparam int unsigned FP_W   = 32;

    localparam logic [7:0] EXP_MAX        = 8'hFF;
    localparam logic [7:0] EXP_OVF_THRESH = 8'd254;

    localparam int unsigned FP_SIGN_BIT = 31;
    localparam int unsigned FP_EXP_HI   = 30;
    localparam int unsigned FP_EXP_LO   = 23;
    localparam int unsigned FP_FRAC_HI  = 22;

    typedef enum logic [1:0] {
        CLS_NORMAL,
        CLS_ZERO,
        CLS_OVERFLOW,
        CLS_UNDERFLOW
    } res_class_e;

    function automatic logic [FP_W-1:0] pack_fp(input logic sign,
                                                input logic [7:0] exp,
                                                input logic [FP_FRAC_HI:0] frac);
        logic [FP_W-1:0] word;
        word = '0;
        word[FP_SIGN_BIT]           = sign;
        word[FP_EXP_HI:FP_EXP_LO]   = exp;
        word[FP_FRAC_HI:0]          = frac;
        return word;
    endfunction

endpackage

// File: rtl/fp_lzc24.sv
// Combinational 24-bit leading-zero counter; returns 24 for an all-zero word.
module fp_lzc24
    import fp_normalize_pack_pkg::*;
(
    input  logic [MANT_W-1:0] din,
    output logic [4:0]        count
);

    // Scan upward so the highest set bit writes last and wins.
    always_comb begin
        count = 5'd24;
        for (int unsigned i = 0; i < MANT_W; i++) begin
            if (din[i]) count = 5'(MANT_W - 1 - i);
        end
    end

endmodule

// File: rtl/fp_normalize_pack.sv
// Four-stage normalize/pack back end of the FP adder: classify+LZC, shift,
// exponent adjust with overflow/underflow, then IEEE-754 single packing.
module fp_normalize_pack
    import fp_normalize_pack_pkg::*;
#(
    parameter int unsigned LATENCY = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             IN_VALID,
    input  logic             SUM_SIGN,
    input  logic [SUM_W-1:0] SUM_MANTISSA,
    input  logic [7:0]       SUM_EXPONENT,
    output logic             OUT_VALID,
    output logic [FP_W-1:0]  FP_RESULT,
    output logic             OUT_OVERFLOW,
    output logic             OUT_UNDERFLOW,
    output logic             OUT_ZERO
);

    logic [LATENCY-1:0] vld;

    // Stage 1: classify and count leading zeros
    logic [4:0]        lzc_count;
    logic              s1_sign, s1_c, s1_z;
    logic [SUM_W-1:0]  s1_mant;
    logic [7:0]        s1_exp;
    logic [4:0]        s1_l;

    fp_lzc24 u_lzc (
        .din   (SUM_MANTISSA[MANT_W-1:0]),
        .count (lzc_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld     <= '0;
            s1_sign <= 1'b0;
            s1_c    <= 1'b0;
            s1_z    <= 1'b0;
            s1_mant <= '0;
            s1_exp  <= '0;
            s1_l    <= '0;
        end else begin
            vld     <= {vld[LATENCY-2:0], IN_VALID};
            s1_sign <= SUM_SIGN;
            s1_c    <= SUM_MANTISSA[SUM_W-1];
            s1_z    <= (SUM_MANTISSA == '0);
            s1_mant <= SUM_MANTISSA;
            s1_exp  <= SUM_EXPONENT;
            s1_l    <= lzc_count;
        end
    end

    // Stage 2: single-level variable shift, truncating
    logic [SUM_W-1:0]  shifted;
    logic              s2_sign, s2_c, s2_z;
    logic [MANT_W-1:0] s2_mant;
    logic [7:0]        s2_exp;
    logic [4:0]        s2_l;

    always_comb begin
        shifted = s1_c ? (s1_mant >> 1) : (s1_mant << s1_l);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_sign <= 1'b0;
            s2_c    <= 1'b0;
            s2_z    <= 1'b0;
            s2_mant <= '0;
            s2_exp  <= '0;
            s2_l    <= '0;
        end else begin
            s2_sign <= s1_sign;
            s2_c    <= s1_c;
            s2_z    <= s1_z;
            s2_mant <= shifted[MANT_W-1:0];
            s2_exp  <= s1_exp;
            s2_l    <= s1_l;
        end
    end

    // Stage 3: exponent adjust; exp - L wraps mod 1024 so bit 9 flags a borrow
    logic [9:0]        e_adj;
    res_class_e        cls;
    logic              s3_sign;
    logic [7:0]        s3_exp;
    logic [FP_FRAC_HI:0] s3_frac;
    res_class_e        s3_cls;

    always_comb begin
        e_adj = {2'b00, s2_exp} + (s2_c ? 10'd1 : (10'd0 - {5'd0, s2_l}));
        cls   = CLS_NORMAL;
        if (s2_z)
            cls = CLS_ZERO;
        else if (s2_c && (s2_exp >= EXP_OVF_THRESH))
            cls = CLS_OVERFLOW;
        else if (!s2_c && (e_adj[9] || (e_adj[8:0] == '0)))
            cls = CLS_UNDERFLOW;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_sign <= 1'b0;
            s3_exp  <= '0;
            s3_frac <= '0;
            s3_cls  <= CLS_ZERO;
        end else begin
            s3_sign <= s2_sign;
            s3_exp  <= e_adj[7:0];
            s3_frac <= s2_mant[FP_FRAC_HI:0];
            s3_cls  <= cls;
        end
    end

    // Stage 4: pack; bubbles drive the result and every flag to zero
    logic [FP_W-1:0] pack_word;
    logic            pack_ovf, pack_unf, pack_zero;

    always_comb begin
        pack_word = '0;
        pack_ovf  = 1'b0;
        pack_unf  = 1'b0;
        pack_zero = 1'b0;
        if (vld[LATENCY-2]) begin
            unique case (s3_cls)
                CLS_ZERO:      pack_zero = 1'b1;
                CLS_OVERFLOW: begin
                    pack_word = pack_fp(s3_sign, EXP_MAX, '0);
                    pack_ovf  = 1'b1;
                end
                CLS_UNDERFLOW: begin
                    pack_word = pack_fp(s3_sign, 8'd0, '0);
                    pack_unf  = 1'b1;
                end
                default:       pack_word = pack_fp(s3_sign, s3_exp, s3_frac);
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            FP_RESULT     <= '0;
            OUT_OVERFLOW  <= 1'b0;
            OUT_UNDERFLOW <= 1'b0;
            OUT_ZERO      <= 1'b0;
        end else begin
            FP_RESULT     <= pack_word;
            OUT_OVERFLOW  <= pack_ovf;
            OUT_UNDERFLOW <= pack_unf;
            OUT_ZERO      <= pack_zero;
        end
    end

    assign OUT_VALID = vld[LATENCY-1];

endmodule
